// File: rtl/conv1d_ring_loader_pkg.sv
// conv1d_pkg: shared constants, FSM state type and depth clamp helper for
// the conv1d input ring loader.
// Optional feature macro: RING_LOADER_CLEAR_EN (adds the CLEAR state).
package conv1d_pkg;

    localparam int KERNEL_LENGTH      = 8;
    localparam int MAX_INPUT_CHANNELS = 128;
    localparam int BUFFERS_SIZE       = KERNEL_LENGTH * MAX_INPUT_CHANNELS;
    localparam int ADDR_W             = $clog2(BUFFERS_SIZE);
    localparam int PADDING            = 4;
    localparam int COL_W              = $clog2(KERNEL_LENGTH);
    localparam int FILL_W             = $clog2(KERNEL_LENGTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READY,
        ST_EMIT
`ifdef RING_LOADER_CLEAR_EN
        ,
        ST_CLEAR
`endif
    } ring_loader_state_e;

    // Depth values above the ring capacity saturate at the capacity.
    function automatic logic [7:0] clamp_depth(input logic [7:0] d);
        return (d > 8'(MAX_INPUT_CHANNELS)) ? 8'(MAX_INPUT_CHANNELS) : d;
    endfunction

endpackage

// File: rtl/conv1d_ring_loader_if.sv
// Word stream (valid/ready) and ring-buffer byte write port of the loader.
// slave = loader side, master = producer / buffer-model side.
interface conv1d_ring_loader_if;
    import conv1d_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;

    modport slave (
        input  in_valid, in_data,
        output in_ready, buf_we, buf_addr, buf_data
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, buf_we, buf_addr, buf_data
    );

endinterface

// File: rtl/conv1d_ring_loader_ring_ptr.sv
// ring_ptr: modulo counter counting 0..i_limit-1 with increment and a
// synchronous clear; the limit may change at run time.
module ring_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic [W:0]   i_limit,
    output logic [W-1:0] o_value
);

    logic [W-1:0] r_value;
    logic         w_at_end;

    assign w_at_end = ({1'b0, r_value} == (i_limit - (W+1)'(1)));
    assign o_value  = r_value;

    // Counter register: clear wins over increment, wrap at the limit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset || i_clr) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= w_at_end ? '0 : r_value + W'(1);
        end
    end

endmodule

// File: rtl/conv1d_ring_loader.sv
// conv1d_ring_loader: unpacks 32-bit words of four int8 activations into
// byte writes of the conv1d input ring, one byte per cycle, and tracks the
// oldest column slot (start_x) and how many columns are filled.
// Optional feature macro: RING_LOADER_CLEAR_EN (pre-pad ring with pad_value).
module conv1d_ring_loader
    import conv1d_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                depth_wr,
    input  logic [7:0]          depth,
    input  logic [7:0]          pad_value,
    input  logic                compute_busy,
    conv1d_ring_loader_if.slave bus,
    output logic                col_valid,
    output logic [COL_W-1:0]    col_slot,
    output logic [COL_W-1:0]    start_x,
    output logic [FILL_W-1:0]   fill_count,
    output logic                window_full
);

    ring_loader_state_e r_state, w_state_next;

    logic [7:0]        r_depth;
    logic [7:0]        r_ch;
    logic [31:0]       r_word;
    logic [1:0]        r_idx;          // byte index currently on buf_*
    logic              r_col_pend;     // byte on buf_* closes a column
    logic              r_buf_we;
    logic [ADDR_W-1:0] r_buf_addr;
    logic [7:0]        r_buf_data;
    logic              r_col_valid;
    logic [COL_W-1:0]  r_col_slot;
    logic [FILL_W-1:0] r_fill;
    logic              r_full;

    logic              w_accept;
    logic              w_issue;        // a byte is registered onto buf_* at this edge
    logic              w_is_pad;
    logic [7:0]        w_issue_data;
    logic [1:0]        w_sel_idx;
    logic              w_col_end;
    logic              w_ptr_last;
    logic [ADDR_W:0]   w_ptr_limit;
    logic [ADDR_W-1:0] w_wr_ptr;
    logic [COL_W-1:0]  w_wr_col;
    logic [FILL_W-1:0] w_fill_inc;
    logic              w_unused_pad;

    assign bus.in_ready = (r_state == ST_READY) && !compute_busy && !depth_wr;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_ptr_limit  = (ADDR_W+1)'(r_depth) * (ADDR_W+1)'(KERNEL_LENGTH);
    assign w_ptr_last   = ({1'b0, w_wr_ptr} == (w_ptr_limit - (ADDR_W+1)'(1)));
    assign w_col_end    = (r_ch == (r_depth - 8'd1));
    assign w_fill_inc   = (r_fill == FILL_W'(KERNEL_LENGTH)) ? r_fill : r_fill + FILL_W'(1);
`ifdef RING_LOADER_CLEAR_EN
    assign w_unused_pad = 1'b0;
`else
    assign w_unused_pad = ^pad_value;
`endif

    // Byte address within the ring, wraps at KERNEL_LENGTH*depth.
    ring_ptr #(.W(ADDR_W)) u_wr_ptr (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (depth_wr),
        .i_inc   (w_issue),
        .i_limit (w_ptr_limit),
        .o_value (w_wr_ptr)
    );

    // Column slot being filled; also the oldest slot reported as start_x.
    ring_ptr #(.W(COL_W)) u_wr_col (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (depth_wr),
        .i_inc   (r_col_pend),
        .i_limit ((COL_W+1)'(KERNEL_LENGTH)),
        .o_value (w_wr_col)
    );

    // Next state and the byte to issue this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a value held and no latch is inferred.
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_is_pad     = 1'b0;
        w_issue_data = 8'h00;
        w_sel_idx    = r_idx + 2'd1;
        case (r_state)
            ST_IDLE: w_state_next = ST_IDLE;
            ST_READY: begin
                if (w_accept) begin
                    w_issue      = 1'b1;
                    w_issue_data = bus.in_data[7:0];
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // Stop after byte 3 or once the byte on the bus ended a column.
                if ((r_idx != 2'd3) && !r_col_pend) begin
                    w_issue      = 1'b1;
                    w_issue_data = r_word[{w_sel_idx, 3'b000} +: 8];
                end else begin
                    w_state_next = ST_READY;
                end
            end
`ifdef RING_LOADER_CLEAR_EN
            ST_CLEAR: begin
                w_issue      = 1'b1;
                w_is_pad     = 1'b1;
                w_issue_data = pad_value;
                if (w_ptr_last) begin
                    w_state_next = ST_READY;
                end
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
        // A depth load overrides everything, including a word mid-emit.
        if (depth_wr) begin
            w_issue  = 1'b0;
            w_is_pad = 1'b0;
            if (clamp_depth(depth) == 8'd0) begin
                w_state_next = ST_IDLE;
            end else begin
`ifdef RING_LOADER_CLEAR_EN
                w_state_next = ST_CLEAR;
`else
                w_state_next = ST_READY;
`endif
            end
        end
    end

    // State, word capture, registered write port and column bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_depth     <= 8'd0;
            r_ch        <= 8'd0;
            r_word      <= 32'd0;
            r_idx       <= 2'd0;
            r_col_pend  <= 1'b0;
            r_buf_we    <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= 8'd0;
            r_col_valid <= 1'b0;
            r_col_slot  <= '0;
            r_fill      <= '0;
            r_full      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_buf_we    <= w_issue;
            r_col_valid <= r_col_pend && !depth_wr;
            if (depth_wr) begin
                r_depth    <= clamp_depth(depth);
                r_ch       <= 8'd0;
                r_idx      <= 2'd0;
                r_col_pend <= 1'b0;
                r_buf_addr <= '0;
                r_buf_data <= 8'd0;
                r_fill     <= '0;
                r_full     <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_buf_addr <= w_wr_ptr;
                    r_buf_data <= w_issue_data;
                end
                r_col_pend <= w_issue && !w_is_pad && w_col_end;
                if (w_issue && !w_is_pad) begin
                    r_ch <= w_col_end ? 8'd0 : r_ch + 8'd1;
                end
                if (w_accept) begin
                    r_word <= bus.in_data;
                    r_idx  <= 2'd0;
                end else if (w_issue && (r_state == ST_EMIT)) begin
                    r_idx <= w_sel_idx;
                end
                if (r_col_pend) begin
                    r_col_slot <= w_wr_col;
                    r_fill     <= w_fill_inc;
                    r_full     <= (w_fill_inc == FILL_W'(KERNEL_LENGTH));
                end
`ifdef RING_LOADER_CLEAR_EN
                // Leaving CLEAR: the whole window already holds padding.
                if ((r_state == ST_CLEAR) && (w_state_next == ST_READY)) begin
                    r_fill <= FILL_W'(KERNEL_LENGTH);
                    r_full <= 1'b1;
                end
`endif
            end
        end
    end

    assign bus.buf_we   = r_buf_we;
    assign bus.buf_addr = r_buf_addr;
    assign bus.buf_data = r_buf_data;
    assign col_valid    = r_col_valid;
    assign col_slot     = r_col_slot;
    assign start_x      = w_wr_col;
    assign fill_count   = r_fill;
    assign window_full  = r_full;

endmodule
